// File: rtl/if_id.sv
// -----------------------------------------------------------------------------
// if_id : fetch-to-decode pipeline register built as a 2-entry in-order skid
// buffer. The main entry is the one presented to decode; the skid entry
// catches the one extra instruction fetch can push in the cycle decode stalls.
// in_ready_o and out_valid_o are decoded from registered state only, so there
// is no combinational path from out_ready_i back to in_ready_o.
// -----------------------------------------------------------------------------
module if_id #(
    parameter logic [31:0] NOP_INST = 32'h00000013,
    parameter int          ADDR_W   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] inst_addr_i,
    input  logic [31:0]       inst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic [31:0]       inst_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] skid_addr;
    logic [31:0]       skid_inst;
    logic              push;
    logic              pop;

    // Handshake flags decoded from registered state (rst only gates ready).
    assign in_ready_o  = (state != FULL) && !rst;
    assign out_valid_o = (state != EMPTY);
    assign push        = in_valid_i && in_ready_o && !flush_i;
    assign pop         = out_valid_o && out_ready_i && !flush_i;

    // Occupancy FSM plus main/skid entries; main entry drives the outputs.
    // NOTE: the main entry is cleared to addr 0 / NOP_INST whenever the buffer
    // drains, so inst_o/inst_addr_o come straight from flops with no output mux.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            // NOTE: non-blocking assignments throughout, so every branch sees
            // the pre-edge values of state and entries.
            state       <= EMPTY;
            inst_addr_o <= '0;
            inst_o      <= NOP_INST;
            skid_addr   <= '0;
            skid_inst   <= NOP_INST;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        inst_addr_o <= inst_addr_i;
                        inst_o      <= inst_i;
                        state       <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        // Decode takes the held entry while fetch refills it.
                        inst_addr_o <= inst_addr_i;
                        inst_o      <= inst_i;
                    end else if (push) begin
                        // Decode stalled: park the new one behind the main entry.
                        skid_addr <= inst_addr_i;
                        skid_inst <= inst_i;
                        state     <= FULL;
                    end else if (pop) begin
                        inst_addr_o <= '0;
                        inst_o      <= NOP_INST;
                        state       <= EMPTY;
                    end
                end
                FULL: begin
                    // Fetch is blocked here, so only a pop can move things.
                    if (pop) begin
                        inst_addr_o <= skid_addr;
                        inst_o      <= skid_inst;
                        skid_addr   <= '0;
                        skid_inst   <= NOP_INST;
                        state       <= ONE;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    inst_addr_o <= '0;
                    inst_o      <= NOP_INST;
                    skid_addr   <= '0;
                    skid_inst   <= NOP_INST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_id.sv
// -----------------------------------------------------------------------------
// tb_if_id : self-checking bench for if_id. Inputs change on the falling edge,
// outputs are compared on the falling edge. A queue model holds the entries
// accepted by the buffer; accepted pushes go in, consumed pops come out.
// -----------------------------------------------------------------------------
module tb_if_id;

    localparam int          AW  = 64;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   inst;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] inst_addr_i;
    logic [31:0]   inst_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic          flush_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [AW-1:0] inst_addr_o;
    logic [31:0]   inst_o;

    entry_t mq[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    logic   last_push = 1'b0;

    if_id #(.NOP_INST(NOP), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_addr_i (inst_addr_i),
        .inst_i      (inst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .flush_i     (flush_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .inst_addr_o (inst_addr_o),
        .inst_o      (inst_o)
    );

    always #5 clk = ~clk;

    // One clock cycle: update the reference queue from the driven inputs.
    task automatic tick();
        logic exp_ready;
        logic push;
        logic pop;
        exp_ready = (mq.size() < 2) && !rst;
        push      = in_valid_i && exp_ready && !flush_i;
        pop       = (mq.size() != 0) && out_ready_i && !flush_i;
        @(posedge clk);
        if (rst || flush_i) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back('{addr: inst_addr_i, inst: inst_i});
        end
        last_push = push && !rst;
        @(negedge clk);
    endtask

    task automatic offer(input logic v, input logic [AW-1:0] a, input logic [31:0] i);
        in_valid_i  = v;
        inst_addr_i = a;
        inst_i      = i;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush_i = 1'b0; out_ready_i = 1'b1;
        offer(1'b1, 64'h8000_0000, 32'h0000_0297);
        tick();
        tick();
        n_checks++;
        if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", out_valid_o); end
        n_checks++;
        if (inst_o !== NOP) begin n_fail++; $display("FAIL rst_inst: got %h want %h", inst_o, NOP); end
        n_checks++;
        if (inst_addr_o !== 64'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", inst_addr_o); end
        n_checks++;
        if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_ready_during: got %b want 0", in_ready_o); end
        rst = 1'b0;
        offer(1'b0, '0, '0);
        #1;
        n_checks++;
        if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after: got %b want 1", in_ready_o); end
        tick();
        n_checks++;
        if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid_after: got %b want 0", out_valid_o); end
    endtask

    task automatic test_pass_through();
        out_ready_i = 1'b1;
        offer(1'b1, 64'h8000_0000, 32'h0000_0297);
        tick();
        n_checks++;
        if ({out_valid_o, inst_addr_o, inst_o} !== {1'b1, 64'h8000_0000, 32'h0000_0297}) begin
            n_fail++; $display("FAIL pt_first: got %b/%h/%h want 1/80000000/00000297", out_valid_o, inst_addr_o, inst_o);
        end
        offer(1'b1, 64'h8000_0004, 32'h0000_0013);
        tick();
        n_checks++;
        if ({out_valid_o, inst_addr_o, inst_o} !== {1'b1, 64'h8000_0004, 32'h0000_0013}) begin
            n_fail++; $display("FAIL pt_second: got %b/%h/%h want 1/80000004/00000013", out_valid_o, inst_addr_o, inst_o);
        end
        offer(1'b0, '0, '0);
        tick();
        n_checks++;
        if ({out_valid_o, inst_addr_o, inst_o} !== {1'b0, 64'h0, NOP}) begin
            n_fail++; $display("FAIL pt_drain: got %b/%h/%h want 0/0/%h", out_valid_o, inst_addr_o, inst_o, NOP);
        end
    endtask

    task automatic test_backpressure();
        out_ready_i = 1'b0;
        offer(1'b1, 64'h8000_0000, 32'h0000_0297);
        tick();
        offer(1'b1, 64'h8000_0004, 32'h0040_0093);
        tick();
        n_checks++;
        if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %b want 0", in_ready_o); end
        offer(1'b1, 64'h8000_0008, 32'h0080_0113);
        tick();
        n_checks++;
        if ({in_ready_o, inst_addr_o, inst_o} !== {1'b0, 64'h8000_0000, 32'h0000_0297}) begin
            n_fail++; $display("FAIL bp_stall_hold: got %b/%h/%h want 0/80000000/00000297", in_ready_o, inst_addr_o, inst_o);
        end
        out_ready_i = 1'b1;
        tick();
        n_checks++;
        if ({out_valid_o, in_ready_o, inst_addr_o, inst_o} !== {2'b11, 64'h8000_0004, 32'h0040_0093}) begin
            n_fail++; $display("FAIL bp_emit_b: got %b%b/%h/%h want 11/80000004/00400093", out_valid_o, in_ready_o, inst_addr_o, inst_o);
        end
        tick();
        offer(1'b0, '0, '0);
        n_checks++;
        if ({out_valid_o, inst_addr_o, inst_o} !== {1'b1, 64'h8000_0008, 32'h0080_0113}) begin
            n_fail++; $display("FAIL bp_emit_c: got %b/%h/%h want 1/80000008/00800113", out_valid_o, inst_addr_o, inst_o);
        end
        tick();
        n_checks++;
        if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b want 0", out_valid_o); end
    endtask

    task automatic test_flush();
        out_ready_i = 1'b0;
        offer(1'b1, 64'h8000_0000, 32'h0000_0297);
        tick();
        offer(1'b1, 64'h8000_0004, 32'h0040_0093);
        tick();
        flush_i = 1'b1;
        offer(1'b1, 64'h8000_0008, 32'h0080_0113);
        tick();
        n_checks++;
        if ({out_valid_o, inst_addr_o, inst_o} !== {1'b0, 64'h0, 32'h0000_0013}) begin
            n_fail++; $display("FAIL fl_empty: got %b/%h/%h want 0/0/00000013", out_valid_o, inst_addr_o, inst_o);
        end
        flush_i = 1'b0; out_ready_i = 1'b1;
        offer(1'b0, '0, '0);
        tick();
        n_checks++;
        if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL fl_c_dropped: got %b want 0", out_valid_o); end
    endtask

    task automatic test_push_pop();
        out_ready_i = 1'b0;
        offer(1'b1, 64'h0000_1000, 32'h1111_1111);
        tick();
        out_ready_i = 1'b1;
        offer(1'b1, 64'h0000_1004, 32'h2222_2222);
        tick();
        n_checks++;
        if ({out_valid_o, in_ready_o, inst_addr_o, inst_o} !== {2'b11, 64'h0000_1004, 32'h2222_2222}) begin
            n_fail++; $display("FAIL pp_present_b: got %b%b/%h/%h want 11/00001004/22222222", out_valid_o, in_ready_o, inst_addr_o, inst_o);
        end
        offer(1'b0, '0, '0);
        tick();
        n_checks++;
        if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL pp_one_state: got %b want 0", out_valid_o); end
    endtask

    task automatic test_reset_mid();
        out_ready_i = 1'b0;
        offer(1'b1, 64'h0000_2000, 32'h3333_3333);
        tick();
        offer(1'b1, 64'h0000_2004, 32'h4444_4444);
        tick();
        rst = 1'b1;
        offer(1'b0, '0, '0);
        tick();
        n_checks++;
        if ({out_valid_o, in_ready_o, inst_o} !== {2'b00, NOP}) begin
            n_fail++; $display("FAIL rm_during: got %b%b/%h want 00/%h", out_valid_o, in_ready_o, inst_o, NOP);
        end
        rst = 1'b0; out_ready_i = 1'b1;
        #1;
        n_checks++;
        if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL rm_ready_after: got %b want 1", in_ready_o); end
        tick();
        n_checks++;
        if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL rm_no_stale: got %b want 0", out_valid_o); end
    endtask

    task automatic test_random_stress();
        entry_t exp;
        logic   exp_valid;
        int     errs;
        errs = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            exp_valid = (mq.size() != 0);
            exp       = exp_valid ? mq[0] : '{addr: '0, inst: NOP};
            n_checks++;
            if ({out_valid_o, inst_addr_o, inst_o} !== {exp_valid, exp.addr, exp.inst}) begin
                n_fail++; errs++;
                if (errs < 10) $display("FAIL rs_out cyc %0d: got %b/%h/%h want %b/%h/%h",
                                        cyc, out_valid_o, inst_addr_o, inst_o, exp_valid, exp.addr, exp.inst);
            end
            n_checks++;
            if (in_ready_o !== ((mq.size() < 2) && !rst)) begin
                n_fail++; errs++;
                if (errs < 10) $display("FAIL rs_ready cyc %0d: got %b want %b", cyc, in_ready_o, (mq.size() < 2) && !rst);
            end
            rst         = ($urandom_range(0, 299) == 0);
            flush_i     = ($urandom_range(0, 39) == 0);
            out_ready_i = ($urandom_range(0, 2) != 0);
            // Fetch keeps an unaccepted offer stable; otherwise it may change.
            if (!(in_valid_i && !last_push)) begin
                offer($urandom_range(0, 3) != 0, {32'h0, $urandom()}, $urandom());
            end
            tick();
        end
        rst = 1'b0; flush_i = 1'b0; offer(1'b0, '0, '0);
        tick();
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0; out_ready_i = 1'b0;
        offer(1'b0, '0, '0);
        @(negedge clk);
        test_reset();
        test_pass_through();
        test_backpressure();
        test_flush();
        test_push_pop();
        test_reset_mid();
        test_random_stress();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
